// File: rtl/slot_rom_arbiter.sv
// Slot card arbiter: C8 expansion-ROM window ownership,
// read-data/IRQ merge and read-drive conflict tracking.
module slot_rom_arbiter #(
  parameter int                   NUM_SLOTS = 7,
  parameter logic [NUM_SLOTS-1:0] ROM_MASK  = 7'b0000010,
  parameter logic [NUM_SLOTS-1:0] IRQ_MASK  = 7'b1111111
) (
  input  logic                   clk_logic,
  input  logic                   system_reset,
  input  logic                   bus_strobe_i,
  input  logic [15:0]            addr_i,
  input  logic                   rw_n_i,
  input  logic                   intcxrom_i,
  input  logic [NUM_SLOTS-1:0]   card_rd_en_i,
  input  logic [8*NUM_SLOTS-1:0] card_data_i,
  input  logic [NUM_SLOTS-1:0]   card_irq_n_i,
  output logic [2:0]             c8_owner_o,
  output logic [NUM_SLOTS-1:0]   c8_en_o,
  output logic [7:0]             data_o,
  output logic                   rd_en_o,
  output logic                   irq_n_o,
  output logic [2:0]             irq_slot_o,
  output logic                   conflict_o,
  output logic [7:0]             conflict_cnt_o
);

  logic                 claim;
  logic [2:0]           claim_slot;
  logic                 rel;
  logic                 bus_ok;
  logic [7:0]           rd_data;
  logic                 conflict;
  logic [NUM_SLOTS-1:0] pending;
  logic [2:0]           irq_slot;

  assign bus_ok  = bus_strobe_i && !intcxrom_i;
  assign rel     = addr_i == 16'hCFFF;
  assign pending = ~card_irq_n_i & IRQ_MASK;

  always_comb begin
    claim      = 1'b0;
    claim_slot = 3'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (addr_i[15:8] == 8'(32'hC1 + i) && ROM_MASK[i]) begin
        claim      = 1'b1;
        claim_slot = 3'(i + 1);
      end
    end
  end

  // Descending scans so the lowest index (slot 1) wins.
  always_comb begin
    rd_data  = 8'hFF;
    irq_slot = 3'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (card_rd_en_i[i]) rd_data = card_data_i[8*i +: 8];
      if (pending[i])      irq_slot = 3'(i + 1);
    end
  end

  assign conflict = rw_n_i && ($countones(card_rd_en_i) >= 2);

  always_comb begin
    c8_en_o = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      c8_en_o[i] = (c8_owner_o == 3'(i + 1)) && !intcxrom_i;
    end
  end

  always_ff @(posedge clk_logic) begin
    if (system_reset) begin
      c8_owner_o     <= 3'd0;
      data_o         <= 8'hFF;
      rd_en_o        <= 1'b0;
      irq_n_o        <= 1'b1;
      irq_slot_o     <= 3'd0;
      conflict_o     <= 1'b0;
      conflict_cnt_o <= 8'd0;
    end else begin
      if (bus_ok && rel)        c8_owner_o <= 3'd0;
      else if (bus_ok && claim) c8_owner_o <= claim_slot;
      data_o     <= rd_data;
      rd_en_o    <= rw_n_i && |card_rd_en_i;
      irq_n_o    <= ~|pending;
      irq_slot_o <= irq_slot;
      conflict_o <= conflict;
      if (bus_strobe_i && conflict && conflict_cnt_o != 8'hFF)
        conflict_cnt_o <= conflict_cnt_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_slot_rom_arbiter.sv
// Scoreboard bench for slot_rom_arbiter: a reference model pushes
// expected outputs per cycle, compared one edge later.
module tb_slot_rom_arbiter;

  localparam logic [6:0] ROMM  = 7'b0000010;
  localparam logic [6:0] IRQM2 = 7'b1111011;

  logic        clk_logic = 1'b0;
  logic        system_reset;
  logic        bus_strobe;
  logic [15:0] addr;
  logic        rw_n;
  logic        intcxrom;
  logic [6:0]  card_rd_en;
  logic [55:0] card_data;
  logic [6:0]  card_irq_n;

  logic [2:0]  c8_owner, c8_owner2;
  logic [6:0]  c8_en, c8_en2;
  logic [7:0]  data, data2;
  logic        rd_en, rd_en2;
  logic        irq_n, irq_n2;
  logic [2:0]  irq_slot, irq_slot2;
  logic        conflict, conflict2;
  logic [7:0]  conflict_cnt, conflict_cnt2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] owner;
    logic [7:0] data;
    logic       rd_en;
    logic       irq_n;
    logic [2:0] irq_slot;
    logic       irq_n2;
    logic [2:0] irq_slot2;
    logic       conflict;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  logic [2:0] m_owner;
  logic [7:0] m_cnt;

  always #5 clk_logic = ~clk_logic;

  slot_rom_arbiter u_dut (
    .clk_logic(clk_logic), .system_reset(system_reset),
    .bus_strobe_i(bus_strobe), .addr_i(addr), .rw_n_i(rw_n),
    .intcxrom_i(intcxrom), .card_rd_en_i(card_rd_en),
    .card_data_i(card_data), .card_irq_n_i(card_irq_n),
    .c8_owner_o(c8_owner), .c8_en_o(c8_en), .data_o(data),
    .rd_en_o(rd_en), .irq_n_o(irq_n), .irq_slot_o(irq_slot),
    .conflict_o(conflict), .conflict_cnt_o(conflict_cnt)
  );

  slot_rom_arbiter #(.IRQ_MASK(IRQM2)) u_dut2 (
    .clk_logic(clk_logic), .system_reset(system_reset),
    .bus_strobe_i(bus_strobe), .addr_i(addr), .rw_n_i(rw_n),
    .intcxrom_i(intcxrom), .card_rd_en_i(card_rd_en),
    .card_data_i(card_data), .card_irq_n_i(card_irq_n),
    .c8_owner_o(c8_owner2), .c8_en_o(c8_en2), .data_o(data2),
    .rd_en_o(rd_en2), .irq_n_o(irq_n2), .irq_slot_o(irq_slot2),
    .conflict_o(conflict2), .conflict_cnt_o(conflict_cnt2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [2:0] first_irq(input logic [6:0] pend);
    for (int i = 0; i < 7; i++)
      if (pend[i]) return 3'(i + 1);
    return 3'd0;
  endfunction

  task automatic step();
    exp_t e;
    int   n;
    int   hi;
    logic [6:0] en_exp;
    e.data = 8'hFF;
    for (int i = 0; i < 7; i++) begin
      if (card_rd_en[i]) begin
        e.data = card_data[8*i +: 8];
        break;
      end
    end
    n = 0;
    for (int i = 0; i < 7; i++) n += int'(card_rd_en[i]);
    e.rd_en     = rw_n && (n > 0);
    e.conflict  = rw_n && (n >= 2);
    e.irq_n     = ~|(~card_irq_n);
    e.irq_slot  = first_irq(~card_irq_n);
    e.irq_n2    = ~|(~card_irq_n & IRQM2);
    e.irq_slot2 = first_irq(~card_irq_n & IRQM2);
    if (bus_strobe && !intcxrom) begin
      hi = int'(addr[15:8]);
      if (addr == 16'hCFFF) m_owner = 3'd0;
      else if (hi >= 'hC1 && hi <= 'hC7 && ROMM[hi - 'hC1])
        m_owner = 3'(hi - 'hC0);
    end
    if (bus_strobe && e.conflict && m_cnt != 8'hFF) m_cnt++;
    if (system_reset) begin
      m_owner     = 3'd0;
      m_cnt       = 8'd0;
      e.data      = 8'hFF;
      e.rd_en     = 1'b0;
      e.conflict  = 1'b0;
      e.irq_n     = 1'b1;
      e.irq_slot  = 3'd0;
      e.irq_n2    = 1'b1;
      e.irq_slot2 = 3'd0;
    end
    e.owner = m_owner;
    e.cnt   = m_cnt;
    sb.push_back(e);
    @(posedge clk_logic);
    #1;
    e = sb.pop_front();
    en_exp = (e.owner == 0 || intcxrom) ? 7'd0
           : 7'(7'd1 << (e.owner - 1));
    chk("owner", 32'(c8_owner), 32'(e.owner));
    chk("c8_en", 32'(c8_en), 32'(en_exp));
    chk("data", 32'(data), 32'(e.data));
    chk("rd_en", 32'(rd_en), 32'(e.rd_en));
    chk("conflict", 32'(conflict), 32'(e.conflict));
    chk("cnt", 32'(conflict_cnt), 32'(e.cnt));
    chk("irq_n", 32'(irq_n), 32'(e.irq_n));
    chk("irq_slot", 32'(irq_slot), 32'(e.irq_slot));
    chk("irq_n_m2", 32'(irq_n2), 32'(e.irq_n2));
    chk("irq_slot_m2", 32'(irq_slot2), 32'(e.irq_slot2));
  endtask

  task automatic bus(input logic [15:0] a, input logic rw);
    bus_strobe = 1'b1;
    addr       = a;
    rw_n       = rw;
    step();
    bus_strobe = 1'b0;
    addr       = 16'h0000;
    rw_n       = 1'b1;
    step();
  endtask

  initial begin
    m_owner      = 3'd0;
    m_cnt        = 8'd0;
    system_reset = 1'b1;
    bus_strobe   = 1'b0;
    addr         = 16'h0000;
    rw_n         = 1'b1;
    intcxrom     = 1'b0;
    card_rd_en   = 7'd0;
    card_data    = '0;
    card_irq_n   = 7'h7F;
    step();
    step();
    system_reset = 1'b0;
    step();

    bus(16'hC200, 1'b1);
    chk("claim_c200", 32'(c8_en), 32'h02);
    bus(16'hCFFF, 1'b1);
    bus(16'hC200, 1'b0);
    bus(16'hC600, 1'b1);
    bus(16'hC100, 1'b1);
    bus(16'hC800, 1'b1);
    intcxrom = 1'b1;
    step();
    bus(16'hCFFF, 1'b0);
    chk("locked_owner", 32'(c8_owner), 32'd2);
    intcxrom = 1'b0;
    step();
    chk("unlock_en", 32'(c8_en), 32'h02);

    card_data[15:8]  = 8'hA5;
    card_data[23:16] = 8'h3C;
    card_data[55:48] = 8'h77;
    card_rd_en = 7'b0000110;
    bus(16'hC0FF, 1'b1);
    bus(16'hC0FF, 1'b0);
    card_rd_en = 7'b0000100;
    bus(16'hC0FF, 1'b1);
    card_rd_en = 7'b1000000;
    bus(16'hC0FF, 1'b1);
    card_rd_en = 7'b1000100;
    step();
    card_rd_en = 7'd0;
    bus(16'hC0FF, 1'b1);

    card_rd_en = 7'b1100001;
    bus_strobe = 1'b1;
    addr       = 16'hC0FF;
    for (int i = 0; i < 300; i++) step();
    bus_strobe = 1'b0;
    step();
    chk("cnt_sat", 32'(conflict_cnt), 32'hFF);
    system_reset = 1'b1;
    step();
    system_reset = 1'b0;
    card_rd_en = 7'd0;
    step();

    card_irq_n = 7'b1011011;
    step();
    chk("irq_pair", 32'(irq_slot), 32'd3);
    card_irq_n = 7'b0111111;
    step();
    card_irq_n = 7'b1111110;
    step();
    card_irq_n = 7'b1111011;
    step();
    card_irq_n = 7'h7F;
    step();

    bus(16'hC200, 1'b1);
    system_reset = 1'b1;
    card_rd_en   = 7'b0000110;
    card_irq_n   = 7'b1011011;
    bus_strobe   = 1'b1;
    addr         = 16'hC200;
    step();
    chk("rst_claim", 32'(c8_owner), 32'd0);
    system_reset = 1'b0;
    bus_strobe   = 1'b0;
    card_rd_en   = 7'd0;
    card_irq_n   = 7'h7F;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slot_rom_arbiter.md
Name: slot_rom_arbiter

Overview:
Owns the shared $C800-$CFFF expansion-ROM window and the card read-data return path for all slot cards, e.g. the Super Serial Card and future ROM-bearing cards.
- Tracks which slot currently owns the C8 window: claim on a CnXX access, release on $CFFF.
- Issues one-hot ROM enables to the cards.
- Merges the per-card read data and IRQ lines onto single bus outputs.
- Flags and counts read-drive conflicts.
Sits between the slot card instances and the top-level bus data driver.

Parameters:
NUM_SLOTS, 7, number of slot positions (slot i+1 maps to index i).
ROM_MASK, 7'b0000010, bit i set means slot i+1 has a C8 ROM and may claim the window.
IRQ_MASK, 7'b1111111, bit i set means the slot i+1 IRQ is honoured.

Ports:
clk_logic  in  1  system logic clock.
system_reset  in  1  synchronous, active-high reset.
bus_strobe_i  in  1  single-cycle pulse, once per bus cycle; the address is valid in that cycle.
addr_i  in  16  bus address.
rw_n_i  in  1  1 = read.
intcxrom_i  in  1  internal CX ROM selected (cards locked out).
card_rd_en_i  in  NUM_SLOTS  per-card read-drive request.
card_data_i  in  8*NUM_SLOTS  per-card read data; index i occupies bits [8i+7:8i].
card_irq_n_i  in  NUM_SLOTS  per-card IRQ, active low.
c8_owner_o  out  3  current window owner slot number; 0 = none.
c8_en_o  out  NUM_SLOTS  one-hot ROM window enable.
data_o  out  8  merged read data.
rd_en_o  out  1  drive bus.
irq_n_o  out  1  merged IRQ, active low.
irq_slot_o  out  3  lowest pending honoured IRQ slot; 0 = none.
conflict_o  out  1  more than one card requested read-drive.
conflict_cnt_o  out  8  saturating conflict count.

Behaviour:
Reset (synchronous, system_reset=1 at a clk_logic edge):
- c8_owner_o=0, data_o=8'hFF, rd_en_o=0, irq_n_o=1, irq_slot_o=0, conflict_o=0, conflict_cnt_o=0.
- Reset overrides all other updates in the same cycle, including a claim or release.

Ownership register. Updates only in cycles with bus_strobe_i=1 and intcxrom_i=0:
- addr_i[15:8]==8'hC0+n, n in 1..NUM_SLOTS, ROM_MASK[n-1]=1: owner <= n next cycle. A different owner is overwritten (last access wins). Reads and writes both claim.
- addr_i==16'hCFFF: owner <= 0. Reads and writes both release.
- CnXX access with ROM_MASK[n-1]=0: owner unchanged.
- All other addresses: owner unchanged.
- intcxrom_i=1: no claim or release; owner is retained.

Window enable (combinational from the owner register):
- c8_en_o[i] = (owner==i+1) && !intcxrom_i.
- At most one bit is set. All zero when owner=0 or intcxrom_i=1.

Read merge (registered, 1-cycle latency from card inputs):
- rd_en_o <= rw_n_i && |card_rd_en_i.
- data_o <= card_data_i slice of the lowest asserted index (fixed priority, slot 1 highest). 8'hFF if none asserted.
- data_o updates even when rw_n_i=0; only rd_en_o is gated by rw_n_i.

Conflicts:
- conflict_o <= rw_n_i && popcount(card_rd_en_i) >= 2 (registered, 1 cycle).
- conflict_cnt_o increments by 1 in cycles where bus_strobe_i=1 and that same conflict condition holds on the current inputs.
- Saturates at 8'hFF; no wrap. Cleared only by reset.

IRQ merge (registered, 1 cycle):
- Pending vector = ~card_irq_n_i & IRQ_MASK.
- irq_n_o <= ~|pending.
- irq_slot_o <= lowest pending index+1, else 0.

Timing:
- Ownership change visible on c8_owner_o/c8_en_o the cycle after the strobe.
- Cards see the claiming CnXX access itself with the old enable, which is correct: the ROM window is used on later $C800 accesses.

Test Plan:
- Reset, then strobe read $C200 (ROM_MASK default) -> next cycle c8_owner_o=2, c8_en_o=7'b0000010. Then strobe $CFFF -> owner=0, c8_en_o=0.
- Owner=2; strobe $C600 (mask bit clear) -> owner stays 2. Set intcxrom_i=1 -> c8_en_o=0, owner stays 2. Strobe $CFFF while intcxrom_i=1 -> owner still 2. Clear intcxrom_i -> c8_en_o=7'b0000010.
- card_rd_en_i=7'b0000110, data slot2=8'hA5, slot3=8'h3C, rw_n_i=1, strobe -> next cycle data_o=8'hA5, rd_en_o=1, conflict_o=1, conflict_cnt_o=1. Same with rw_n_i=0 -> rd_en_o=0, conflict_o=0, count unchanged.
- 300 strobed conflict cycles -> conflict_cnt_o=8'hFF and holds. Reset -> 0.
- card_irq_n_i=7'b1011011 (slots 3 and 6 low) -> irq_n_o=0, irq_slot_o=3. IRQ_MASK[2]=0 -> irq_slot_o=6. All lines high -> irq_n_o=1, irq_slot_o=0.
- Owner=2; system_reset asserted in the same cycle as a strobed $C200 -> owner=0 and every output at its reset value.
